// File: rtl/fifo_tx_if.sv
// fifo_tx_if: host-write / MAC-read bundle for the transmit FIFO.
interface fifo_tx_if #(parameter int DATA_WIDTH = 8, parameter int ADDR_WIDTH = 4);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  last_in;
  logic                  write_enable;
  logic                  read_enable;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  last_out;
  logic                  out_valid;
  logic                  full_flag;
  logic                  empty_flag;
  logic [ADDR_WIDTH:0]   frame_count;
  logic                  overflow;
  modport master (
    output data_in, last_in, write_enable, read_enable,
    input  data_out, last_out, out_valid, full_flag, empty_flag, frame_count, overflow
  );
  modport slave (
    input  data_in, last_in, write_enable, read_enable,
    output data_out, last_out, out_valid, full_flag, empty_flag, frame_count, overflow
  );
endinterface

// File: rtl/fifo_tx.sv
// fifo_tx: transmit byte FIFO with frame tracking; define FIFO_TX_STORE_FWD_EN for
// store-and-forward (only committed frames readable, overflowed frames rewound and dropped).
module fifo_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  fifo_tx_if.slave    bus
);
  typedef enum logic [1:0] {W_IDLE, W_FRAME, W_DROP} wstate_t;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   frame_count_q, frame_count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  last_out_q, last_out_d, out_valid_q, out_valid_d, overflow_q, overflow_d;
  wstate_t               state_q, state_d;
  logic                  full, empty, wr_acc, rd_acc, ovf_ev;
  logic [DATA_WIDTH:0]   rd_word;
`ifdef FIFO_TX_STORE_FWD_EN
  logic [ADDR_WIDTH:0]   commit_ptr_q, commit_ptr_d;
`endif
  always_comb begin
    full          = (wr_ptr_q - rd_ptr_q) == FULL_CNT;
`ifdef FIFO_TX_STORE_FWD_EN
    empty         = rd_ptr_q == commit_ptr_q;
`else
    empty         = rd_ptr_q == wr_ptr_q;
`endif
    wr_acc        = bus.write_enable && !full && state_q != W_DROP;
    ovf_ev        = bus.write_enable && full && state_q != W_DROP;
    rd_acc        = bus.read_enable && !empty;
    rd_word       = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    rd_ptr_d      = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    data_out_d    = rd_acc ? rd_word[DATA_WIDTH-1:0] : data_out_q;
    last_out_d    = rd_acc ? rd_word[DATA_WIDTH] : last_out_q;
    out_valid_d   = rd_acc;
    overflow_d    = ovf_ev;
    frame_count_d = frame_count_q + (ADDR_WIDTH+1)'(wr_acc && bus.last_in)
                                  - (ADDR_WIDTH+1)'(rd_acc && rd_word[DATA_WIDTH]);
`ifdef FIFO_TX_STORE_FWD_EN
    commit_ptr_d  = (wr_acc && bus.last_in) ? wr_ptr_q + 1'b1 : commit_ptr_q;
    wr_ptr_d      = wr_acc ? wr_ptr_q + 1'b1 : ovf_ev ? commit_ptr_q : wr_ptr_q;
    state_d       = ovf_ev ? (bus.last_in ? W_IDLE : W_DROP) :
                    state_q == W_DROP ? ((bus.write_enable && bus.last_in) ? W_IDLE : W_DROP) :
                    wr_acc ? (bus.last_in ? W_IDLE : W_FRAME) : state_q;
`else
    // Cut-through drops only the offending byte, so the frame state is untouched on overflow.
    wr_ptr_d      = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    state_d       = wr_acc ? (bus.last_in ? W_IDLE : W_FRAME) : state_q;
`endif
  end
  always_ff @(posedge clk) if (wr_acc) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {bus.last_in, bus.data_in};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      frame_count_q <= '0;
      data_out_q    <= '0;
      last_out_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      overflow_q    <= 1'b0;
      state_q       <= W_IDLE;
`ifdef FIFO_TX_STORE_FWD_EN
      commit_ptr_q  <= '0;
`endif
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      frame_count_q <= frame_count_d;
      data_out_q    <= data_out_d;
      last_out_q    <= last_out_d;
      out_valid_q   <= out_valid_d;
      overflow_q    <= overflow_d;
      state_q       <= state_d;
`ifdef FIFO_TX_STORE_FWD_EN
      commit_ptr_q  <= commit_ptr_d;
`endif
    end
  end
  assign bus.data_out    = data_out_q;
  assign bus.last_out    = last_out_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.overflow    = overflow_q;
  assign bus.frame_count = frame_count_q;
  assign bus.full_flag   = full;
  assign bus.empty_flag  = empty;
endmodule

// File: tb/tb_fifo_tx.sv
// tb_fifo_tx: directed checks of fifo_tx; mode-specific tests follow FIFO_TX_STORE_FWD_EN.
module tb_fifo_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  fifo_tx_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) b ();
  fifo_tx #(.DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [7:0] d, input logic l);
    b.data_in = d; b.last_in = l; b.write_enable = 1'b1;
    tick();
    b.write_enable = 1'b0; b.last_in = 1'b0;
  endtask
  task automatic rd();
    b.read_enable = 1'b1;
    tick();
    b.read_enable = 1'b0;
  endtask
  task automatic test_reset();
    b.data_in = '0; b.last_in = 1'b0; b.write_enable = 1'b0; b.read_enable = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (b.empty_flag !== 1'b1) begin errors++; $display("FAIL rst_empty got %0b exp 1", b.empty_flag); end
    checks++; if (b.full_flag !== 1'b0) begin errors++; $display("FAIL rst_full got %0b exp 0", b.full_flag); end
    checks++; if (b.frame_count !== 5'd0) begin errors++; $display("FAIL rst_fc got %0d exp 0", b.frame_count); end
    checks++; if ({b.data_out, b.last_out, b.out_valid, b.overflow} !== 11'd0) begin errors++; $display("FAIL rst_outs got %h/%0b/%0b/%0b exp 0", b.data_out, b.last_out, b.out_valid, b.overflow); end
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_frame();
    wr(8'hAA, 1'b0);
    wr(8'hBB, 1'b1);
    checks++; if (b.frame_count !== 5'd1) begin errors++; $display("FAIL frame_fc got %0d exp 1", b.frame_count); end
    rd();
    checks++; if ({b.out_valid, b.data_out, b.last_out} !== {1'b1, 8'hAA, 1'b0}) begin errors++; $display("FAIL frame_rd0 got v=%0b %h l=%0b exp v=1 aa l=0", b.out_valid, b.data_out, b.last_out); end
    rd();
    checks++; if ({b.out_valid, b.data_out, b.last_out} !== {1'b1, 8'hBB, 1'b1}) begin errors++; $display("FAIL frame_rd1 got v=%0b %h l=%0b exp v=1 bb l=1", b.out_valid, b.data_out, b.last_out); end
    checks++; if ({b.frame_count, b.empty_flag} !== {5'd0, 1'b1}) begin errors++; $display("FAIL frame_end got fc=%0d e=%0b exp fc=0 e=1", b.frame_count, b.empty_flag); end
    tick();
    checks++; if (b.out_valid !== 1'b0) begin errors++; $display("FAIL frame_pulse got %0b exp 0", b.out_valid); end
  endtask
  task automatic test_concurrent();
    wr(8'hD1, 1'b1);
    b.read_enable = 1'b1;
    wr(8'hC0, 1'b1);
    b.read_enable = 1'b0;
    checks++; if (b.frame_count !== 5'd1) begin errors++; $display("FAIL conc_fc got %0d exp 1", b.frame_count); end
    checks++; if ({b.out_valid, b.data_out, b.last_out} !== {1'b1, 8'hD1, 1'b1}) begin errors++; $display("FAIL conc_rd0 got v=%0b %h l=%0b exp v=1 d1 l=1", b.out_valid, b.data_out, b.last_out); end
    rd();
    checks++; if ({b.out_valid, b.data_out, b.last_out} !== {1'b1, 8'hC0, 1'b1}) begin errors++; $display("FAIL conc_rd1 got v=%0b %h l=%0b exp v=1 c0 l=1", b.out_valid, b.data_out, b.last_out); end
    checks++; if ({b.frame_count, b.empty_flag} !== {5'd0, 1'b1}) begin errors++; $display("FAIL conc_end got fc=%0d e=%0b exp fc=0 e=1", b.frame_count, b.empty_flag); end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) wr(8'h60 + 8'(i), i == 3);
    b.read_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({b.out_valid, b.data_out, b.last_out} !== {1'b1, 8'h60 + 8'(i), i == 3}) begin errors++; $display("FAIL b2b_rd%0d got v=%0b %h l=%0b exp v=1 %h l=%0b", i, b.out_valid, b.data_out, b.last_out, 8'h60 + 8'(i), i == 3); end
    end
    tick();
    b.read_enable = 1'b0;
    checks++; if ({b.out_valid, b.data_out, b.empty_flag} !== {1'b0, 8'h63, 1'b1}) begin errors++; $display("FAIL b2b_hold got v=%0b %h e=%0b exp v=0 63 e=1", b.out_valid, b.data_out, b.empty_flag); end
  endtask
  task automatic test_async_reset();
    wr(8'h77, 1'b1);
    wr(8'h88, 1'b0);
    rd();
    checks++; if ({b.out_valid, b.data_out} !== {1'b1, 8'h77}) begin errors++; $display("FAIL ares_pre got v=%0b %h exp v=1 77", b.out_valid, b.data_out); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({b.out_valid, b.data_out, b.last_out, b.empty_flag, b.frame_count} !== {1'b0, 8'h00, 1'b0, 1'b1, 5'd0}) begin errors++; $display("FAIL ares_now got v=%0b %h l=%0b e=%0b fc=%0d exp v=0 00 l=0 e=1 fc=0", b.out_valid, b.data_out, b.last_out, b.empty_flag, b.frame_count); end
    tick();
    rst_n = 1'b1;
    wr(8'h99, 1'b1);
    rd();
    checks++; if ({b.out_valid, b.data_out, b.last_out} !== {1'b1, 8'h99, 1'b1}) begin errors++; $display("FAIL ares_post got v=%0b %h l=%0b exp v=1 99 l=1", b.out_valid, b.data_out, b.last_out); end
  endtask
`ifdef FIFO_TX_STORE_FWD_EN
  task automatic test_store_fwd();
    wr(8'h11, 1'b0);
    wr(8'h22, 1'b0);
    rd();
    checks++; if ({b.out_valid, b.empty_flag} !== 2'b01) begin errors++; $display("FAIL sf_hold got v=%0b e=%0b exp v=0 e=1", b.out_valid, b.empty_flag); end
    wr(8'h33, 1'b1);
    checks++; if (b.empty_flag !== 1'b0) begin errors++; $display("FAIL sf_commit got %0b exp 0", b.empty_flag); end
    for (int i = 0; i < 3; i++) begin
      rd();
      checks++; if ({b.out_valid, b.data_out, b.last_out} !== {1'b1, 8'h11 * 8'(i + 1), i == 2}) begin errors++; $display("FAIL sf_rd%0d got v=%0b %h l=%0b exp v=1 %h l=%0b", i, b.out_valid, b.data_out, b.last_out, 8'h11 * 8'(i + 1), i == 2); end
    end
  endtask
  task automatic test_overflow();
    for (int i = 0; i < 16; i++) wr(8'h80 + 8'(i), 1'b0);
    checks++; if (b.full_flag !== 1'b1) begin errors++; $display("FAIL ovf_full got %0b exp 1", b.full_flag); end
    wr(8'hEE, 1'b0);
    checks++; if ({b.overflow, b.full_flag, b.empty_flag} !== 3'b101) begin errors++; $display("FAIL ovf_rewind got o=%0b f=%0b e=%0b exp o=1 f=0 e=1", b.overflow, b.full_flag, b.empty_flag); end
    wr(8'hE1, 1'b0);
    checks++; if (b.overflow !== 1'b0) begin errors++; $display("FAIL ovf_pulse got %0b exp 0", b.overflow); end
    wr(8'hE2, 1'b1);
    checks++; if ({b.empty_flag, b.frame_count} !== {1'b1, 5'd0}) begin errors++; $display("FAIL ovf_drop got e=%0b fc=%0d exp e=1 fc=0", b.empty_flag, b.frame_count); end
    wr(8'h5A, 1'b0);
    wr(8'h5B, 1'b1);
    rd();
    checks++; if ({b.data_out, b.last_out} !== {8'h5A, 1'b0}) begin errors++; $display("FAIL ovf_rd0 got %h l=%0b exp 5a l=0", b.data_out, b.last_out); end
    rd();
    checks++; if ({b.data_out, b.last_out, b.empty_flag} !== {8'h5B, 1'b1, 1'b1}) begin errors++; $display("FAIL ovf_rd1 got %h l=%0b e=%0b exp 5b l=1 e=1", b.data_out, b.last_out, b.empty_flag); end
  endtask
`else
  task automatic test_cut_through();
    wr(8'h44, 1'b0);
    checks++; if (b.empty_flag !== 1'b0) begin errors++; $display("FAIL ct_avail got %0b exp 0", b.empty_flag); end
    rd();
    checks++; if ({b.out_valid, b.data_out, b.last_out, b.frame_count} !== {1'b1, 8'h44, 1'b0, 5'd0}) begin errors++; $display("FAIL ct_rd got v=%0b %h l=%0b fc=%0d exp v=1 44 l=0 fc=0", b.out_valid, b.data_out, b.last_out, b.frame_count); end
    wr(8'h45, 1'b1);
    rd();
    checks++; if ({b.data_out, b.last_out, b.frame_count} !== {8'h45, 1'b1, 5'd0}) begin errors++; $display("FAIL ct_close got %h l=%0b fc=%0d exp 45 l=1 fc=0", b.data_out, b.last_out, b.frame_count); end
  endtask
  task automatic test_overflow();
    for (int i = 0; i < 16; i++) wr(8'h80 + 8'(i), 1'b0);
    checks++; if (b.full_flag !== 1'b1) begin errors++; $display("FAIL ovf_full got %0b exp 1", b.full_flag); end
    wr(8'hEE, 1'b1);
    checks++; if ({b.overflow, b.full_flag, b.frame_count} !== {2'b11, 5'd0}) begin errors++; $display("FAIL ovf_drop got o=%0b f=%0b fc=%0d exp o=1 f=1 fc=0", b.overflow, b.full_flag, b.frame_count); end
    tick();
    checks++; if (b.overflow !== 1'b0) begin errors++; $display("FAIL ovf_pulse got %0b exp 0", b.overflow); end
    for (int i = 0; i < 16; i++) begin
      rd();
      checks++; if ({b.data_out, b.last_out} !== {8'h80 + 8'(i), 1'b0}) begin errors++; $display("FAIL ovf_rd%0d got %h l=%0b exp %h l=0", i, b.data_out, b.last_out, 8'h80 + 8'(i)); end
    end
    checks++; if (b.empty_flag !== 1'b1) begin errors++; $display("FAIL ovf_empty got %0b exp 1", b.empty_flag); end
    wr(8'h5B, 1'b1);
    rd();
    checks++; if ({b.data_out, b.last_out, b.frame_count} !== {8'h5B, 1'b1, 5'd0}) begin errors++; $display("FAIL ovf_next got %h l=%0b fc=%0d exp 5b l=1 fc=0", b.data_out, b.last_out, b.frame_count); end
  endtask
`endif
  initial begin
    test_reset();
    test_frame();
`ifdef FIFO_TX_STORE_FWD_EN
    test_store_fwd();
`else
    test_cut_through();
`endif
    test_overflow();
    test_concurrent();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_tx.md
# fifo_tx

Transmit-side byte FIFO for the Ethernet MAC, mirroring the receive FIFO in the opposite direction. The host writes frame bytes tagged with an end-of-frame marker; the MAC transmitter reads them out with a registered, one-cycle-latency read port. The block tracks whole frames and can hold back reads until a complete frame is stored (store-and-forward), so the transmitter never underruns mid-frame.

## Interface
- DATA_WIDTH, 8, byte width of data_in/data_out
- DEPTH, 16, entries; power of two, at least 4
- ADDR_WIDTH, 4, log2(DEPTH); pointers are ADDR_WIDTH+1 bits

- clk  input  1  single clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- data_in  input  DATA_WIDTH  write byte
- last_in  input  1  marks data_in as final byte of frame
- write_enable  input  1  write request
- read_enable  input  1  read request from MAC transmitter
- data_out  output  DATA_WIDTH  registered read byte
- last_out  output  1  registered end-of-frame tag for data_out
- out_valid  output  1  one-cycle pulse: data_out/last_out updated this cycle
- full_flag  output  1  DEPTH entries stored
- empty_flag  output  1  no readable entry
- frame_count  output  ADDR_WIDTH+1  complete frames stored
- overflow  output  1  one-cycle pulse: a write was rejected

## Operation
- Storage: DEPTH x (DATA_WIDTH+1) array; bit DATA_WIDTH holds last tag. Array not reset.
- Pointers: wr_ptr, commit_ptr (start of uncommitted frame), rd_ptr. full_flag = (wr_ptr - rd_ptr == DEPTH).
- Write accepted iff write_enable && !full_flag (registered view; a same-cycle read does not free space for the write).
- Accepted write: mem[wr_ptr] <= {last_in, data_in}; wr_ptr++. If last_in: commit_ptr <= wr_ptr+1, frame_count++.
- Write FSM states: W_IDLE (no frame open), W_FRAME (frame open), W_DROP (discarding rest of overflowed frame).
  - W_IDLE -> W_FRAME on accepted write with last_in=0; W_FRAME -> W_IDLE on accepted write with last_in=1.
  - Rejected write (full) in W_IDLE/W_FRAME: overflow pulses; handling per Configuration.
  - W_DROP: every write discarded, no overflow pulse; write with last_in=1 -> W_IDLE.
- Read accepted iff read_enable && !empty_flag. Next edge: data_out/last_out <= mem[rd_ptr], rd_ptr++, out_valid=1. If tag set, frame_count--.
- Rejected read: data_out/last_out hold, out_valid=0.
- frame_count: increment and decrement in same cycle -> unchanged. Max value DEPTH; never wraps.

## Timing
- Reset (async assert): wr_ptr=commit_ptr=rd_ptr=0, frame_count=0, state W_IDLE, data_out=0, last_out=0, out_valid=0, overflow=0, full_flag=0, empty_flag=1. Deasserting mid-frame leaves partial frame discarded.
- Read latency: 1 cycle from sampled read_enable to data_out/out_valid. Back-to-back reads give one byte per cycle.
- Write-to-readable: empty_flag/frame_count update the cycle after the qualifying write edge.
- full_flag/empty_flag are combinational from registered pointers; no same-cycle bypass.
- Pointer wrap: ADDR_WIDTH+1-bit pointers, index with low ADDR_WIDTH bits; full/empty exact across wrap.

## Configuration
- FIFO_TX_STORE_FWD_EN defined (store-and-forward):
  - empty_flag = (rd_ptr == commit_ptr); only committed frames are readable.
  - Overflow: wr_ptr <= commit_ptr (rewind partial frame); next state W_DROP if last_in=0, else W_IDLE.
- Undefined (cut-through):
  - empty_flag = (rd_ptr == wr_ptr); bytes readable the cycle after writing.
  - Overflow: only the offending byte is dropped; FSM stays as is; W_DROP unreachable. If the dropped byte had last_in=1, frame_count is not incremented.

## Test plan
- Reset: assert rst_n=0 mid-traffic -> all outputs at reset values immediately, empty_flag=1, frame_count=0.
- Write 8'hAA, then 8'hBB with last_in=1 -> frame_count=1; two reads -> out_valid pulses carrying AA/last_out=0 then BB/last_out=1; frame_count=0, empty_flag=1.
- Store-forward: write 11,22 (last_in=0), read_enable=1 -> no out_valid, empty_flag=1; write 33 with last_in=1 -> empty_flag=0, three reads return 11,22,33.
- Overflow (store-forward, DEPTH=16): 16 writes with last_in=0 -> full_flag=1; 17th write -> overflow=1 one cycle, full_flag=0, empty_flag=1; further writes through last_in=1 discarded; next frame 5A,5B(last) reads back exactly.
- Concurrency: with one committed frame of 1 byte, same cycle read it and write C0 with last_in=1 -> frame_count stays 1; read returns C0 with last_out=1.
- Cut-through (macro undefined): write 44 -> empty_flag=0 next cycle, read returns 44 with last_out=0, frame_count=0.
